// File: rtl/decoder_sweep_ctrl.sv
// One-hot LED decoder with registered output; index comes from the switches
// (direct mode) or from a prescaled up/down/ping-pong sweep sequencer.
module decoder_sweep_ctrl #(
  parameter  int unsigned SEL_W    = 4,
  parameter  int unsigned PRESCALE = 50_000_000,
  localparam int unsigned OUT_W    = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] SW,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] LED,
  output logic [SEL_W-1:0] idx,
  output logic             tick
);

  localparam int unsigned PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
  localparam logic [SEL_W-1:0]  IDX_MAX   = '1;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_PING   = 2'b11;

  logic [1:0]        mode_q;
  logic              dir;
  logic [PCNT_W-1:0] pcnt;

  logic [SEL_W-1:0]  idx_n, step_idx;
  logic [PCNT_W-1:0] pcnt_n;
  logic              dir_n, step_dir, tick_n;
  logic [OUT_W-1:0]  led_n;

  // State register; LED register holds the sampled enable applied to idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      mode_q <= MODE_DIRECT;
      dir    <= 1'b0;
      pcnt   <= '0;
      tick   <= 1'b0;
      LED    <= '0;
    end else begin
      idx    <= idx_n;
      mode_q <= mode;
      dir    <= dir_n;
      pcnt   <= pcnt_n;
      tick   <= tick_n;
      LED    <= led_n;
    end
  end

  // Index the sweep would move to on a step in the current mode.
  always_comb begin
    step_idx = idx;
    step_dir = dir;
    case (mode)
      MODE_UP:   step_idx = idx + SEL_W'(1);
      MODE_DOWN: step_idx = idx - SEL_W'(1);
      MODE_PING: begin
        if (!dir) begin
          if (idx == IDX_MAX) begin
            step_dir = 1'b1;
            step_idx = idx - SEL_W'(1);
          end else begin
            step_idx = idx + SEL_W'(1);
          end
        end else begin
          if (idx == '0) begin
            step_dir = 1'b0;
            step_idx = idx + SEL_W'(1);
          end else begin
            step_idx = idx - SEL_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Next state: a mode change restarts the prescaler and outranks a due step.
  always_comb begin
    idx_n  = idx;
    pcnt_n = pcnt;
    dir_n  = dir;
    tick_n = 1'b0;
    if (mode != mode_q) begin
      pcnt_n = '0;
      dir_n  = 1'b0;
      if (mode == MODE_DIRECT) idx_n = SW;
    end else if (mode == MODE_DIRECT) begin
      idx_n  = SW;
      pcnt_n = '0;
    end else if (enable) begin
      if (pcnt == PCNT_LAST) begin
        pcnt_n = '0;
        tick_n = 1'b1;
        idx_n  = step_idx;
        dir_n  = step_dir;
      end else begin
        pcnt_n = pcnt + PCNT_W'(1);
      end
    end
  end

  // Registered one-hot decode of the next index, blanked by enable.
  always_comb begin
    led_n = '0;
    if (enable) led_n = OUT_W'(1) << idx_n;
  end

endmodule

// File: tb/tb_decoder_sweep_ctrl.sv
// Randomised and directed bench for decoder_sweep_ctrl against a behavioural
// model of the index/prescaler/enable rules.
module tb_decoder_sweep_ctrl;

  localparam int unsigned SEL_W    = 4;
  localparam int unsigned OUT_W    = 16;
  localparam int unsigned PRESCALE = 4;
  localparam int          N        = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [SEL_W-1:0] SW;
  logic             enable;
  logic [1:0]       mode;
  logic [OUT_W-1:0] LED;
  logic [SEL_W-1:0] idx;
  logic             tick;

  bit clk_run = 1'b1;
  bit chk_on  = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  decoder_sweep_ctrl #(.SEL_W(SEL_W), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst_n(rst_n), .SW(SW), .enable(enable), .mode(mode),
    .LED(LED), .idx(idx), .tick(tick)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer index, signed direction, cycle counter.
  int m_idx, m_cnt, m_dir, m_prev_mode;
  bit m_en, m_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx = 0; m_cnt = 0; m_dir = 1; m_prev_mode = 0; m_en = 0; m_tick = 0;
    end else begin
      int nxt;
      m_en   = enable;
      m_tick = 0;
      if (int'(mode) != m_prev_mode) begin
        m_cnt = 0;
        m_dir = 1;
        if (mode == 2'b00) m_idx = int'(SW);
      end else if (mode == 2'b00) begin
        m_idx = int'(SW);
        m_cnt = 0;
      end else if (enable) begin
        m_cnt++;
        if (m_cnt == PRESCALE) begin
          m_cnt  = 0;
          m_tick = 1;
          case (mode)
            2'b01: m_idx = (m_idx + 1) % N;
            2'b10: m_idx = (m_idx + N - 1) % N;
            default: begin
              nxt = m_idx + m_dir;
              if (nxt < 0 || nxt > N - 1) begin
                m_dir = -m_dir;
                nxt   = m_idx + m_dir;
              end
              m_idx = nxt;
            end
          endcase
        end
      end
      m_prev_mode = int'(mode);
    end
  end

  // Every-cycle comparison against the model.
  bit prev_tick = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      logic [OUT_W-1:0] exp_led;
      exp_led = m_en ? (OUT_W'(1) << m_idx) : '0;
      check("model_led", 32'(LED), 32'(exp_led));
      check("model_idx", 32'(idx), 32'(m_idx));
      check("model_tick", 32'(tick), 32'(m_tick));
      check("tick_back_to_back", 32'(tick && prev_tick), 32'd0);
      prev_tick = tick;
    end else begin
      prev_tick = 0;
    end
  end

  task automatic wait_tick(input int budget, output int n);
    bit seen = 0;
    n = 0;
    while (n < budget && !seen) begin
      @(negedge clk);
      n++;
      if (tick) seen = 1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL tick_timeout: no tick within %0d cycles at %0t", budget, $time);
    end
  endtask

  initial begin
    int n;
    int exp_q[$];
    rst_n = 1'b0; SW = '0; enable = 1'b0; mode = 2'b00;
    #1;
    check("reset_led", 32'(LED), 32'h0);
    check("reset_idx", 32'(idx), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Direct mode: LED follows SW one cycle later.
    enable = 1'b1;
    for (int s = 0; s < N; s++) begin
      SW = SEL_W'(s);
      @(negedge clk);
      check("direct_led", 32'(LED), 32'(OUT_W'(1) << s));
      check("direct_idx", 32'(idx), 32'(s));
    end
    enable = 1'b0; SW = 4'd9;
    @(negedge clk);
    check("blank_led", 32'(LED), 32'h0);
    check("blank_idx", 32'(idx), 32'd9);

    // Sweep up from 14: entry edge plus PRESCALE edges to first step.
    enable = 1'b1; SW = 4'd14;
    @(negedge clk);
    mode = 2'b01;
    wait_tick(20, n); check("up_first_gap", 32'(n), 32'd5);
    check("up_idx0", 32'(idx), 32'd15); check("up_led0", 32'(LED), 32'h8000);
    wait_tick(20, n); check("up_gap", 32'(n), 32'd4);
    check("up_idx1", 32'(idx), 32'd0);  check("up_led1", 32'(LED), 32'h0001);
    wait_tick(20, n); check("up_gap", 32'(n), 32'd4);
    check("up_idx2", 32'(idx), 32'd1);  check("up_led2", 32'(LED), 32'h0002);

    // Sweep down from 1.
    mode = 2'b00; SW = 4'd1;
    @(negedge clk);
    mode = 2'b10;
    wait_tick(20, n); check("dn_first_gap", 32'(n), 32'd5);
    check("dn_idx0", 32'(idx), 32'd0);  check("dn_led0", 32'(LED), 32'h0001);
    wait_tick(20, n);
    check("dn_idx1", 32'(idx), 32'd15); check("dn_led1", 32'(LED), 32'h8000);
    wait_tick(20, n);
    check("dn_idx2", 32'(idx), 32'd14); check("dn_led2", 32'(LED), 32'h4000);

    // Ping-pong from 13: 14,15, down to 0, then 1.
    mode = 2'b00; SW = 4'd13;
    @(negedge clk);
    mode = 2'b11;
    exp_q.push_back(14); exp_q.push_back(15);
    for (int v = 14; v >= 0; v--) exp_q.push_back(v);
    exp_q.push_back(1);
    foreach (exp_q[i]) begin
      wait_tick(20, n);
      check("pp_gap", 32'(n), (i == 0) ? 32'd5 : 32'd4);
      check("pp_idx", 32'(idx), 32'(exp_q[i]));
    end

    // Enable pause after 2 counted cycles freezes prescaler and index.
    mode = 2'b00; SW = 4'd3;
    @(negedge clk);
    mode = 2'b01;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("pause_tick", 32'(tick), 32'd0);
      check("pause_led", 32'(LED), 32'h0);
      check("pause_idx", 32'(idx), 32'd3);
    end
    enable = 1'b1;
    wait_tick(20, n); check("resume_gap", 32'(n), 32'd2);
    check("resume_idx", 32'(idx), 32'd4);
    check("resume_led", 32'(LED), 32'h0010);

    // Mode change on the edge a step is due: no step, no tick.
    repeat (3) @(negedge clk);
    mode = 2'b10;
    @(negedge clk);
    check("mchg_tick", 32'(tick), 32'd0);
    check("mchg_idx", 32'(idx), 32'd4);

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
      enable = ($urandom_range(0, 7) != 0);
      SW = SEL_W'($urandom);
      @(negedge clk);
    end

    // Asynchronous reset with the clock stopped.
    mode = 2'b01; enable = 1'b1;
    repeat (2) @(negedge clk);
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_led", 32'(LED), 32'h0);
    check("async_idx", 32'(idx), 32'h0);
    check("async_tick", 32'(tick), 32'h0);
    #3 rst_n = 1'b1;
    #2 clk_run = 1'b1;
    // First edge after release registers the mode change from the reset mode.
    wait_tick(20, n); check("post_rst_gap", 32'(n), 32'd5);
    check("post_rst_idx", 32'(idx), 32'd1);
    check("post_rst_led", 32'(LED), 32'h0002);

    @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
